gray_counter: RTL and testbench

Registered binary-to-Gray up/down counter, the encode-side counterpart to the team's Gray-to-binary decoder. It keeps a binary count and drives a Gray-coded copy of that count straight from flops, so the Gray output is glitch-free. Intended uses are async-FIFO pointer generation and Gray-encoded position and sequence outputs. The decoder consumes its Gray output on the far side of a clock-domain crossing.

---
 rtl/gray_pkg.sv | 43 ++++
 rtl/gray_counter_if.sv | 25 ++
 rtl/bin2gray_comb.sv | 15 +
 rtl/gray_counter.sv | 80 ++++++++
 tb/tb_gray_counter.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/gray_pkg.sv
// gray_pkg: shared Gray-code helpers used by both the encode-side counter and
// the Gray-to-binary decoder, so both directions come from a single source.
//   MAX_WIDTH      : widest code the helpers support; callers zero-extend in
//                    and size-cast the result back to their own width.
//   op_e           : per-edge operation selected by the counter priority logic.
//   bin2gray()     : gray = bin ^ (bin >> 1)
//   gray2bin()     : prefix-XOR from the MSB down
//   max_count()    : 2^w - 1, the all-ones count for a w-bit counter
package gray_pkg;

   localparam int unsigned MAX_WIDTH = 32;

   typedef enum logic [1:0] {
      OP_HOLD,
      OP_STEP,
      OP_LOAD,
      OP_CLR
   } op_e;

   function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] bin);
      return bin ^ (bin >> 1);
   endfunction

   function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] gray);
      logic [MAX_WIDTH-1:0] bin;
      bin = '0;
      bin[MAX_WIDTH-1] = gray[MAX_WIDTH-1];
      for (int unsigned i = MAX_WIDTH - 1; i > 0; i--) begin
         bin[i-1] = bin[i] ^ gray[i-1];
      end
      return bin;
   endfunction

   function automatic logic [MAX_WIDTH-1:0] max_count(input int unsigned w);
      logic [MAX_WIDTH-1:0] m;
      m = '0;
      for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
         if (i < w) m[i] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/gray_counter_if.sv
// gray_counter_if: control and result bundle of the Gray up/down counter.
//   en, up, clr, load, load_val : controls (master -> slave)
//   bin_o, gray_o, wrap_o       : registered results (slave -> master)
interface gray_counter_if #(
   parameter int unsigned WIDTH = 4
);
   logic             en;
   logic             up;
   logic             clr;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] bin_o;
   logic [WIDTH-1:0] gray_o;
   logic             wrap_o;

   modport master (
      output en, up, clr, load, load_val,
      input  bin_o, gray_o, wrap_o
   );

   modport slave (
      input  en, up, clr, load, load_val,
      output bin_o, gray_o, wrap_o
   );
endinterface

// File: rtl/bin2gray_comb.sv
// bin2gray_comb: purely combinational WIDTH-bit binary-to-Gray encoder.
//   bin_i  : binary input
//   gray_o : bin_i ^ (bin_i >> 1)
module bin2gray_comb
   import gray_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic [WIDTH-1:0] bin_i,
   output logic [WIDTH-1:0] gray_o
);

   assign gray_o = WIDTH'(bin2gray(MAX_WIDTH'(bin_i)));

endmodule

// File: rtl/gray_counter.sv
// gray_counter: registered binary up/down counter with a flop-driven Gray copy.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset (loads RESET_VAL)
//   bus    : gray_counter_if slave
//            en/up step the count, clr clears to 0, load loads load_val;
//            priority clr > load > en > hold.
//            bin_o/gray_o are the registered count and its Gray code,
//            wrap_o pulses for one cycle after a step that wrapped.
// gray_q is encoded from the next binary value and registered alongside
// bin_q, so gray_o never passes through output-side logic and stays glitch-free.
module gray_counter
   import gray_pkg::*;
#(
   parameter int unsigned WIDTH     = 4,
   parameter int unsigned RESET_VAL = 0
) (
   input  logic          clk,
   input  logic          rst_n,
   gray_counter_if.slave bus
);

   localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RESET_VAL);
   localparam logic [WIDTH-1:0] RST_GRAY = WIDTH'(bin2gray(MAX_WIDTH'(RESET_VAL)));
   localparam logic [WIDTH-1:0] MAX_CNT  = WIDTH'(max_count(WIDTH));

   logic [WIDTH-1:0] bin_q, bin_d;
   logic [WIDTH-1:0] gray_q, gray_d;
   logic             wrap_q, wrap_d;
   op_e              op;

   always_comb begin
      op = OP_HOLD;
      if (bus.clr)       op = OP_CLR;
      else if (bus.load) op = OP_LOAD;
      else if (bus.en)   op = OP_STEP;
   end

   always_comb begin
      bin_d  = bin_q;
      wrap_d = 1'b0;
      unique case (op)
         OP_CLR:  bin_d = '0;
         OP_LOAD: bin_d = bus.load_val;
         OP_STEP: begin
            if (bus.up) begin
               bin_d  = bin_q + 1'b1;
               wrap_d = (bin_q == MAX_CNT);
            end else begin
               bin_d  = bin_q - 1'b1;
               wrap_d = (bin_q == '0);
            end
         end
         default: bin_d = bin_q;
      endcase
   end

   bin2gray_comb #(
      .WIDTH(WIDTH)
   ) u_bin2gray (
      .bin_i (bin_d),
      .gray_o(gray_d)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bin_q  <= RST_BIN;
         gray_q <= RST_GRAY;
         wrap_q <= 1'b0;
      end else begin
         bin_q  <= bin_d;
         gray_q <= gray_d;
         wrap_q <= wrap_d;
      end
   end

   assign bus.bin_o  = bin_q;
   assign bus.gray_o = gray_q;
   assign bus.wrap_o = wrap_q;

endmodule

// File: tb/tb_gray_counter.sv
module tb_gray_counter;
   import gray_pkg::*;

   logic clk    = 1'b0;
   logic rst_n  = 1'b1;
   logic rst2_n = 1'b1;
   int   errors = 0;
   int   checks = 0;

   localparam logic [3:0] GRAY_UP [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                                          4'b0110, 4'b0111, 4'b0101, 4'b0100,
                                          4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                          4'b1010, 4'b1011, 4'b1001, 4'b1000};

   gray_counter_if #(.WIDTH(4)) bus1 ();
   gray_counter_if #(.WIDTH(4)) bus2 ();

   gray_counter #(.WIDTH(4), .RESET_VAL(0)) dut1 (.clk(clk), .rst_n(rst_n),  .bus(bus1));
   gray_counter #(.WIDTH(4), .RESET_VAL(5)) dut2 (.clk(clk), .rst_n(rst2_n), .bus(bus2));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      bus1.en = 0; bus1.up = 0; bus1.clr = 0; bus1.load = 0; bus1.load_val = '0;
      bus2.en = 0; bus2.up = 0; bus2.clr = 0; bus2.load = 0; bus2.load_val = '0;
      #1;
      rst_n = 0; rst2_n = 0;
      #1;
      checks++;
      if ({bus1.bin_o, bus1.gray_o, bus1.wrap_o} !== {4'b0000, 4'b0000, 1'b0}) begin
         errors++;
         $display("FAIL reset_dut1: got bin=%b gray=%b wrap=%b, want bin=0000 gray=0000 wrap=0",
                  bus1.bin_o, bus1.gray_o, bus1.wrap_o);
      end
      checks++;
      if ({bus2.bin_o, bus2.gray_o, bus2.wrap_o} !== {4'b0101, 4'b0111, 1'b0}) begin
         errors++;
         $display("FAIL reset_dut2: got bin=%b gray=%b wrap=%b, want bin=0101 gray=0111 wrap=0",
                  bus2.bin_o, bus2.gray_o, bus2.wrap_o);
      end
      #1;
      rst_n = 1; rst2_n = 1;
   endtask

   task automatic test_count_up();
      logic [3:0] prev, eb, eg;
      logic       ew;
      bus1.en = 1; bus1.up = 1;
      for (int i = 1; i <= 16; i++) begin
         prev = bus1.gray_o;
         tick();
         eb = 4'(i);
         eg = GRAY_UP[i % 16];
         ew = (i == 16);
         checks++;
         if ({bus1.bin_o, bus1.gray_o, bus1.wrap_o} !== {eb, eg, ew}) begin
            errors++;
            $display("FAIL count_up[%0d]: got bin=%b gray=%b wrap=%b, want bin=%b gray=%b wrap=%b",
                     i, bus1.bin_o, bus1.gray_o, bus1.wrap_o, eb, eg, ew);
         end
         checks++;
         if ($countones(prev ^ bus1.gray_o) != 1) begin
            errors++;
            $display("FAIL count_up_onebit[%0d]: got gray %b -> %b, want exactly one bit changed",
                     i, prev, bus1.gray_o);
         end
         checks++;
         if (4'(gray2bin(MAX_WIDTH'(bus1.gray_o))) !== eb) begin
            errors++;
            $display("FAIL count_up_loopback[%0d]: got decoded=%b, want %b",
                     i, 4'(gray2bin(MAX_WIDTH'(bus1.gray_o))), eb);
         end
      end
      bus1.en = 0;
   endtask

   task automatic test_count_down();
      logic [3:0] prev;
      bus1.en = 1; bus1.up = 0;
      prev = bus1.gray_o;
      tick();
      checks++;
      if ({bus1.bin_o, bus1.gray_o, bus1.wrap_o} !== {4'b1111, 4'b1000, 1'b1}) begin
         errors++;
         $display("FAIL count_down_wrap: got bin=%b gray=%b wrap=%b, want bin=1111 gray=1000 wrap=1",
                  bus1.bin_o, bus1.gray_o, bus1.wrap_o);
      end
      checks++;
      if ($countones(prev ^ bus1.gray_o) != 1) begin
         errors++;
         $display("FAIL count_down_onebit: got gray %b -> %b, want exactly one bit changed",
                  prev, bus1.gray_o);
      end
      tick();
      checks++;
      if ({bus1.bin_o, bus1.gray_o, bus1.wrap_o} !== {4'b1110, 4'b1001, 1'b0}) begin
         errors++;
         $display("FAIL count_down_next: got bin=%b gray=%b wrap=%b, want bin=1110 gray=1001 wrap=0",
                  bus1.bin_o, bus1.gray_o, bus1.wrap_o);
      end
      bus1.en = 0;
   endtask

   task automatic test_load_priority();
      bus1.load = 1; bus1.load_val = 4'b1010;
      tick();
      checks++;
      if ({bus1.bin_o, bus1.gray_o, bus1.wrap_o} !== {4'b1010, 4'b1111, 1'b0}) begin
         errors++;
         $display("FAIL load_1010: got bin=%b gray=%b wrap=%b, want bin=1010 gray=1111 wrap=0",
                  bus1.bin_o, bus1.gray_o, bus1.wrap_o);
      end
      bus1.load_val = 4'b0011; bus1.en = 1; bus1.up = 1;
      tick();
      checks++;
      if ({bus1.bin_o, bus1.gray_o, bus1.wrap_o} !== {4'b0011, 4'b0010, 1'b0}) begin
         errors++;
         $display("FAIL load_over_en: got bin=%b gray=%b wrap=%b, want bin=0011 gray=0010 wrap=0",
                  bus1.bin_o, bus1.gray_o, bus1.wrap_o);
      end
      bus1.load_val = 4'b1111; bus1.en = 0;
      tick();
      checks++;
      if ({bus1.bin_o, bus1.gray_o, bus1.wrap_o} !== {4'b1111, 4'b1000, 1'b0}) begin
         errors++;
         $display("FAIL load_1111: got bin=%b gray=%b wrap=%b, want bin=1111 gray=1000 wrap=0",
                  bus1.bin_o, bus1.gray_o, bus1.wrap_o);
      end
      // at 1111 an up-step would wrap; clr must win and suppress wrap_o
      bus1.clr = 1; bus1.load = 1; bus1.load_val = 4'b0101; bus1.en = 1; bus1.up = 1;
      tick();
      checks++;
      if ({bus1.bin_o, bus1.gray_o, bus1.wrap_o} !== {4'b0000, 4'b0000, 1'b0}) begin
         errors++;
         $display("FAIL clr_priority: got bin=%b gray=%b wrap=%b, want bin=0000 gray=0000 wrap=0",
                  bus1.bin_o, bus1.gray_o, bus1.wrap_o);
      end
      bus1.clr = 0; bus1.load = 0; bus1.en = 0;
   endtask

   task automatic test_hold();
      bus1.load = 1; bus1.load_val = 4'b0110;
      tick();
      bus1.load = 0; bus1.en = 0;
      for (int i = 0; i < 5; i++) begin
         bus1.up = i[0];
         tick();
         checks++;
         if ({bus1.bin_o, bus1.gray_o, bus1.wrap_o} !== {4'b0110, 4'b0101, 1'b0}) begin
            errors++;
            $display("FAIL hold[%0d]: got bin=%b gray=%b wrap=%b, want bin=0110 gray=0101 wrap=0",
                     i, bus1.bin_o, bus1.gray_o, bus1.wrap_o);
         end
      end
      bus1.en = 1; bus1.up = 1;
      tick();
      checks++;
      if ({bus1.bin_o, bus1.gray_o, bus1.wrap_o} !== {4'b0111, 4'b0100, 1'b0}) begin
         errors++;
         $display("FAIL hold_then_step: got bin=%b gray=%b wrap=%b, want bin=0111 gray=0100 wrap=0",
                  bus1.bin_o, bus1.gray_o, bus1.wrap_o);
      end
      bus1.en = 0;
   endtask

   task automatic test_async_reset();
      bus2.load = 1; bus2.load_val = 4'b1001;
      tick();
      bus2.load = 0;
      checks++;
      if ({bus2.bin_o, bus2.gray_o, bus2.wrap_o} !== {4'b1001, 4'b1101, 1'b0}) begin
         errors++;
         $display("FAIL async_preload: got bin=%b gray=%b wrap=%b, want bin=1001 gray=1101 wrap=0",
                  bus2.bin_o, bus2.gray_o, bus2.wrap_o);
      end
      #2;
      rst2_n = 0;
      #1;
      checks++;
      if ({bus2.bin_o, bus2.gray_o, bus2.wrap_o} !== {4'b0101, 4'b0111, 1'b0}) begin
         errors++;
         $display("FAIL async_reset_now: got bin=%b gray=%b wrap=%b, want bin=0101 gray=0111 wrap=0",
                  bus2.bin_o, bus2.gray_o, bus2.wrap_o);
      end
      bus2.en = 1; bus2.up = 1;
      tick();
      checks++;
      if ({bus2.bin_o, bus2.gray_o, bus2.wrap_o} !== {4'b0101, 4'b0111, 1'b0}) begin
         errors++;
         $display("FAIL async_reset_held: got bin=%b gray=%b wrap=%b, want bin=0101 gray=0111 wrap=0",
                  bus2.bin_o, bus2.gray_o, bus2.wrap_o);
      end
      #2;
      rst2_n = 1;
      tick();
      checks++;
      if ({bus2.bin_o, bus2.gray_o, bus2.wrap_o} !== {4'b0110, 4'b0101, 1'b0}) begin
         errors++;
         $display("FAIL async_resume: got bin=%b gray=%b wrap=%b, want bin=0110 gray=0101 wrap=0",
                  bus2.bin_o, bus2.gray_o, bus2.wrap_o);
      end
      tick();
      checks++;
      if ({bus2.bin_o, bus2.gray_o, bus2.wrap_o} !== {4'b0111, 4'b0100, 1'b0}) begin
         errors++;
         $display("FAIL async_resume2: got bin=%b gray=%b wrap=%b, want bin=0111 gray=0100 wrap=0",
                  bus2.bin_o, bus2.gray_o, bus2.wrap_o);
      end
      checks++;
      if (4'(gray2bin(MAX_WIDTH'(bus2.gray_o))) !== 4'b0111) begin
         errors++;
         $display("FAIL async_loopback: got decoded=%b, want 0111",
                  4'(gray2bin(MAX_WIDTH'(bus2.gray_o))));
      end
      bus2.en = 0;
   endtask

   initial begin
      test_reset();
      test_count_up();
      test_count_down();
      test_load_priority();
      test_hold();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
